fir_sq_wave_source: RTL and testbench

Synthesizable AXI4-Stream square-wave transmitter that feeds the `s_axis_fir_*` slave port of the FIR filter with a bipolar square wave. It replaces file-based stimulus so the FIR can be exercised on the FPGA without a testbench. The block fully honours `tready` backpressure and keeps data stable while a beat is pending.

---
 rtl/fir_sq_wave_source.sv | 119 +++++++++++
 tb/tb_fir_sq_wave_source.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sq_wave_source.sv
// ============================================================================
// fir_sq_wave_source : AXI4-Stream bipolar square-wave source for the FIR input.
// Optional tlast output enabled by defining FIR_SQ_SRC_TLAST_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_sq_wave_source #(
  parameter int unsigned            DATA_WIDTH  = 16,
  parameter int unsigned            HALF_PERIOD = 15,
  parameter logic [DATA_WIDTH-1:0]  HIGH_VAL    = 16'h7FFF,
  parameter logic [DATA_WIDTH-1:0]  LOW_VAL     = 16'h8001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] m_axis_fir_tdata,
  output logic                  m_axis_fir_tvalid,
  input  logic                  m_axis_fir_tready,
`ifdef FIR_SQ_SRC_TLAST_EN
  output logic                  m_axis_fir_tlast,
`endif
  output logic                  phase,
  output logic [31:0]           beat_count
);

  localparam logic [15:0] CNT_LAST = 16'(HALF_PERIOD - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  phase_q, phase_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [31:0]           beat_q, beat_d;
  logic                  hs;

  // tvalid is the RUN state itself, so it can only fall on a handshake or reset
  assign m_axis_fir_tvalid = (state_q == S_RUN);
  assign hs                = m_axis_fir_tvalid & m_axis_fir_tready;

  always_comb begin
    state_d = state_q;
    tdata_d = tdata_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    beat_d  = hs ? beat_q + 32'd1 : beat_q;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
          tdata_d = HIGH_VAL;
          phase_d = 1'b0;
          cnt_d   = 16'd0;
        end
      end
      S_RUN: begin
        if (hs) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = 16'd0;
            phase_d = ~phase_q;
          end else begin
            cnt_d   = cnt_q + 16'd1;
          end
          tdata_d = phase_d ? LOW_VAL : HIGH_VAL;
          if (!enable) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tdata_q <= '0;
      phase_q <= 1'b0;
      cnt_q   <= 16'd0;
      beat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      tdata_q <= tdata_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
    end
  end

  assign m_axis_fir_tdata = tdata_q;
  assign phase            = phase_q;
  assign beat_count       = beat_q;

`ifdef FIR_SQ_SRC_TLAST_EN
  logic last_q, last_d;

  // Marks the final sample of the LOW half, i.e. the end of a full period
  always_comb begin
    last_d = last_q;
    if (state_q == S_IDLE && enable) begin
      last_d = 1'b0;
    end else if (state_q == S_RUN && hs) begin
      last_d = phase_d & (cnt_d == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b0;
    else       last_q <= last_d;
  end

  assign m_axis_fir_tlast = last_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_sq_wave_source.sv
// ============================================================================
// tb_fir_sq_wave_source : directed table-driven bench for fir_sq_wave_source.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_sq_wave_source;

  localparam logic [15:0] HI = 16'h7FFF;
  localparam logic [15:0] LO = 16'h8001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        tready = 1'b0;
  logic [15:0] tdata;
  logic        tvalid;
  logic        ph;
  logic [31:0] bcnt;

  logic        enable1 = 1'b0;
  logic        tready1 = 1'b0;
  logic [15:0] tdata1;
  logic        tvalid1;
  logic        ph1;
  logic [31:0] bcnt1;

`ifdef FIR_SQ_SRC_TLAST_EN
  logic        tlast;
  logic        tlast1;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_sq_wave_source u_dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .m_axis_fir_tdata  (tdata),
    .m_axis_fir_tvalid (tvalid),
    .m_axis_fir_tready (tready),
`ifdef FIR_SQ_SRC_TLAST_EN
    .m_axis_fir_tlast  (tlast),
`endif
    .phase             (ph),
    .beat_count        (bcnt)
  );

  fir_sq_wave_source #(.HALF_PERIOD(1)) u_dut1 (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable1),
    .m_axis_fir_tdata  (tdata1),
    .m_axis_fir_tvalid (tvalid1),
    .m_axis_fir_tready (tready1),
`ifdef FIR_SQ_SRC_TLAST_EN
    .m_axis_fir_tlast  (tlast1),
`endif
    .phase             (ph1),
    .beat_count        (bcnt1)
  );

  typedef struct {
    logic        en;
    logic        rdy;
    logic        vld;
    logic [15:0] data;
    logic        ph;
    logic        last;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[61];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic rdy);
    enable = en;
    tready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Sample index s of the default square wave (HALF_PERIOD=15)
  function automatic logic [15:0] sample(input int s);
    return ((s / 15) % 2 == 1) ? LO : HI;
  endfunction

  function automatic logic is_last(input int s);
    return (s % 30) == 29;
  endfunction

  task automatic check_out(input string nm, input logic vld, input logic [15:0] d,
                           input logic p, input logic l, input logic [31:0] c);
    check({nm, ".tvalid"}, 32'(tvalid), 32'(vld));
    if (vld) begin
      check({nm, ".tdata"}, 32'(tdata), 32'(d));
      check({nm, ".phase"}, 32'(ph), 32'(p));
`ifdef FIR_SQ_SRC_TLAST_EN
      check({nm, ".tlast"}, 32'(tlast), 32'(l));
`else
      if (l === 1'bx) n_err++;
`endif
    end
    check({nm, ".beat_count"}, bcnt, c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    tready = 1'b0;
    enable1 = 1'b0;
    tready1 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int  s;
    int  n;
    logic hs;
    logic [15:0] d;

    // Continuous run table: vector j is checked after j handshakes
    vecs[0] = '{en: 1'b1, rdy: 1'b1, vld: 1'b1, data: HI, ph: 1'b0, last: 1'b0, cnt: 32'd0};
    for (int j = 1; j < 61; j++) begin
      vecs[j] = '{en: 1'b1, rdy: 1'b1, vld: 1'b1, data: sample(j),
                  ph: ((j / 15) % 2 == 1), last: is_last(j), cnt: 32'(j)};
    end

    // Reset state
    #2;
    check("reset.tvalid", 32'(tvalid), 32'd0);
    check("reset.tdata", 32'(tdata), 32'd0);
    check("reset.phase", 32'(ph), 32'd0);
    check("reset.beat_count", bcnt, 32'd0);
`ifdef FIR_SQ_SRC_TLAST_EN
    check("reset.tlast", 32'(tlast), 32'd0);
`endif
    do_reset();
    step(1'b0, 1'b1);
    check("idle.tvalid", 32'(tvalid), 32'd0);

    for (int j = 0; j < 61; j++) begin
      step(vecs[j].en, vecs[j].rdy);
      check_out($sformatf("run[%0d]", j), vecs[j].vld, vecs[j].data,
                vecs[j].ph, vecs[j].last, vecs[j].cnt);
    end

    // Backpressure: 10-clock stall while beat 7 (sample 6) is pending
    do_reset();
    step(1'b1, 1'b1);
    for (int k = 1; k <= 6; k++) step(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0);
      check_out("stall", 1'b1, HI, 1'b0, 1'b0, 32'd6);
    end
    for (int k = 7; k <= 30; k++) begin
      step(1'b1, 1'b1);
      check_out($sformatf("resume[%0d]", k), 1'b1, sample(k), ((k / 15) % 2 == 1), is_last(k), 32'(k));
    end

    // Stop while stalled on beat 20, then restart
    do_reset();
    step(1'b1, 1'b1);
    for (int k = 1; k <= 19; k++) step(1'b1, 1'b1);
    check_out("beat20", 1'b1, LO, 1'b1, 1'b0, 32'd19);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      check_out("stop_pending", 1'b1, LO, 1'b1, 1'b0, 32'd19);
    end
    step(1'b0, 1'b1);
    check_out("stop_hs", 1'b0, 16'h0, 1'b0, 1'b0, 32'd20);
    step(1'b0, 1'b1);
    check_out("stopped", 1'b0, 16'h0, 1'b0, 1'b0, 32'd20);
    step(1'b1, 1'b1);
    check_out("restart", 1'b1, HI, 1'b0, 1'b0, 32'd20);
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 1'b1);
      check_out($sformatf("restart[%0d]", k), 1'b1, sample(k), ((k / 15) % 2 == 1), is_last(k), 32'(20 + k));
    end

`ifdef FIR_SQ_SRC_TLAST_EN
    // tlast held through a stall on beat 30
    do_reset();
    step(1'b1, 1'b1);
    for (int k = 1; k <= 29; k++) step(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      check_out("tlast_stall", 1'b1, LO, 1'b1, 1'b1, 32'd29);
    end
    step(1'b1, 1'b1);
    check_out("tlast_after", 1'b1, HI, 1'b0, 1'b0, 32'd30);
`endif

    // Asynchronous reset between edges with a beat pending
    step(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("areset.tvalid", 32'(tvalid), 32'd0);
    check("areset.tdata", 32'(tdata), 32'd0);
    check("areset.phase", 32'(ph), 32'd0);
    check("areset.beat_count", bcnt, 32'd0);
    #2;
    reset = 1'b0;
    step(1'b1, 1'b1);
    check_out("areset.restart", 1'b1, HI, 1'b0, 1'b0, 32'd0);

    // HALF_PERIOD=1 with tready toggling: accepted beats alternate
    do_reset();
    enable1 = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      tready1 = (i % 2 == 1);
      #1;
      hs = tvalid1 & tready1;
      d  = tdata1;
      @(posedge clk);
      #1;
      if (hs) begin
        check($sformatf("hp1.beat[%0d]", n), 32'(d), 32'((n % 2 == 1) ? LO : HI));
        n++;
      end
    end
    check("hp1.beat_count", bcnt1, 32'(n));
    check("hp1.beats_seen", 32'(n > 4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1);
  end

endmodule

`default_nettype wire
